dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: serves 4-beat line-fill reads and single-word byte-masked
// writes from a synchronous SRAM, with a programmable number of wait states.
module dmem_responder #(
  parameter int ADDR_W   = 14,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              D_req_read,
  input  logic [31:0]       D_addr,
  input  logic [31:0]       D_in,
  input  logic [3:0]        D_strb,
  output logic [31:0]       D_out,
  output logic              D_wait,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic [3:0]        mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_di,
  input  logic [31:0]       mem_do
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_BURST, RD_LAST, WR_WAIT, WR_EXEC
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);

  state_t              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [3:0]          strb_q, strb_d;
  logic                dwait_q, dwait_d;
  logic                rd_vld_q, rd_vld_d;
  logic                cs_q, cs_d;
  logic                oe_q, oe_d;
  logic [3:0]          web_q, web_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [31:0]         di_q, di_d;
  logic                unused_addr_bits_s;

  assign unused_addr_bits_s = ^{D_addr[31:ADDR_W+2], D_addr[1:0]};

  // Next-state, request latching and next values of the registered SRAM/handshake outputs
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    strb_d   = strb_q;
    case (state_q)
      IDLE: begin
        beat_d = 2'd0;
        wcnt_d = 4'd0;
        if (D_req_read) begin
          addr_d  = D_addr[ADDR_W+1:2];
          data_d  = D_in;
          strb_d  = D_strb;
          state_d = (WAIT_CYC == 0) ? RD_BURST : RD_WAIT;
        end else if (D_strb != 4'hF) begin
          addr_d  = D_addr[ADDR_W+1:2];
          data_d  = D_in;
          strb_d  = D_strb;
          state_d = (WAIT_CYC == 0) ? WR_EXEC : WR_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          state_d = RD_BURST;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      RD_BURST: begin
        if (beat_q == 2'd3) begin
          state_d = RD_LAST;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      RD_LAST: state_d = IDLE;
      WR_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          state_d = WR_EXEC;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      WR_EXEC: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cs_d     = 1'b0;
    oe_d     = 1'b0;
    web_d    = 4'hF;
    maddr_d  = '0;
    di_d     = 32'h0;
    dwait_d  = 1'b1;
    rd_vld_d = 1'b0;
    // Outputs are registered, so they are derived from the state being entered.
    if (state_d == RD_BURST) begin
      cs_d    = 1'b1;
      oe_d    = 1'b1;
      maddr_d = {addr_d[ADDR_W-1:2], beat_d};
    end else if (state_d == WR_EXEC) begin
      cs_d    = 1'b1;
      web_d   = strb_d;
      di_d    = data_d;
      maddr_d = addr_d;
      dwait_d = 1'b0;
    end else begin
      cs_d = 1'b0;
    end
    if (state_q == RD_BURST) begin
      dwait_d  = 1'b0;
      rd_vld_d = 1'b1;
    end else begin
      rd_vld_d = 1'b0;
    end
  end

  // State, latched request and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      wcnt_q   <= 4'd0;
      addr_q   <= '0;
      data_q   <= 32'h0;
      strb_q   <= 4'h0;
      dwait_q  <= 1'b1;
      rd_vld_q <= 1'b0;
      cs_q     <= 1'b0;
      oe_q     <= 1'b0;
      web_q    <= 4'hF;
      maddr_q  <= '0;
      di_q     <= 32'h0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
      dwait_q  <= dwait_d;
      rd_vld_q <= rd_vld_d;
      cs_q     <= cs_d;
      oe_q     <= oe_d;
      web_q    <= web_d;
      maddr_q  <= maddr_d;
      di_q     <= di_d;
    end
  end

  // SRAM data lands one cycle after issue, so beats pass straight through.
  assign D_out    = rd_vld_q ? mem_do : 32'h0;
  assign D_wait   = dwait_q;
  assign mem_cs   = cs_q;
  assign mem_oe   = oe_q;
  assign mem_web  = web_q;
  assign mem_addr = maddr_q;
  assign mem_di   = di_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: WAIT_CYC=2 instance for the main
// scenarios and a WAIT_CYC=0 instance for zero-wait latency and address wrap.
module tb_dmem_responder;
  logic        clk;
  logic        rst;
  logic        mem_init;
  int          checks;
  int          failures;

  logic        req, req0;
  logic [31:0] addr, addr0, din, din0, dout, dout0, mdi, mdi0, mdo, mdo0;
  logic [3:0]  strb, strb0, mweb, mweb0;
  logic        dwait, dwait0, mcs, mcs0, moe, moe0;
  logic [13:0] maddr, maddr0;

  logic [31:0] mem  [0:255];
  logic [31:0] mem0 [0:255];

  dmem_responder #(.ADDR_W(14), .WAIT_CYC(2)) dut (
    .clk(clk), .rst(rst), .D_req_read(req), .D_addr(addr), .D_in(din), .D_strb(strb),
    .D_out(dout), .D_wait(dwait), .mem_cs(mcs), .mem_oe(moe), .mem_web(mweb),
    .mem_addr(maddr), .mem_di(mdi), .mem_do(mdo)
  );

  dmem_responder #(.ADDR_W(14), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .D_req_read(req0), .D_addr(addr0), .D_in(din0), .D_strb(strb0),
    .D_out(dout0), .D_wait(dwait0), .mem_cs(mcs0), .mem_oe(moe0), .mem_web(mweb0),
    .mem_addr(maddr0), .mem_di(mdi0), .mem_do(mdo0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: registered read data, active-low byte writes
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]  <= 32'h1000_0000 + i;
        mem0[i] <= 32'h2000_0000 + i;
      end
    end else begin
      if (mcs && moe) mdo <= mem[maddr[7:0]];
      if (mcs && !moe) begin
        for (int b = 0; b < 4; b++)
          if (!mweb[b]) mem[maddr[7:0]][8*b +: 8] <= mdi[8*b +: 8];
      end
      if (mcs0 && moe0) mdo0 <= mem0[maddr0[7:0]];
    end
  end

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; addr = 32'h0000_0104; strb = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (dwait !== 1'b1 || mcs !== 1'b0 || moe !== 1'b0 || mweb !== 4'hF || dout !== 32'h0 ||
          maddr !== 14'h0 || dwait0 !== 1'b1 || mcs0 !== 1'b0) begin
        failures++;
        $display("FAIL reset k%0d: wait=%b cs=%b oe=%b web=%h dout=%h addr=%h wait0=%b cs0=%b, expected 1 0 0 f 0 0 1 0",
                 k, dwait, mcs, moe, mweb, dout, maddr, dwait0, mcs0);
      end
    end
    req = 1'b0; strb = 4'hF; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (dwait !== 1'b1 || mcs !== 1'b0 || mweb !== 4'hF || mdi !== 32'h0 || dout !== 32'h0) begin
        failures++;
        $display("FAIL idle k%0d: wait=%b cs=%b web=%h di=%h dout=%h, expected 1 0 f 0 0",
                 k, dwait, mcs, mweb, mdi, dout);
      end
    end
  endtask

  // Read whose request is sampled at the next edge; exp_w holds beats 0..3
  task automatic run_read(input logic [31:0] a, input logic [13:0] base,
                          input logic [3:0][31:0] exp_w, input bit drop_early, input string nm);
    logic        e_cs, e_wait;
    logic [13:0] e_addr;
    logic [31:0] e_dout;
    req = 1'b1; addr = a;
    @(negedge clk);
    strb = 4'hF;
    if (drop_early) begin
      req = 1'b0; addr = 32'hFFFF_FFFF;
    end
    for (int k = 1; k <= 8; k++) begin
      e_cs   = (k >= 3 && k <= 6);
      e_addr = e_cs ? base + 14'(k - 3) : 14'h0;
      e_wait = !(k >= 4 && k <= 7);
      e_dout = e_wait ? 32'h0 : exp_w[k-4];
      checks++;
      if (mcs !== e_cs || moe !== e_cs || mweb !== 4'hF || maddr !== e_addr ||
          dwait !== e_wait || dout !== e_dout) begin
        failures++;
        $display("FAIL %s cyc%0d: cs=%b oe=%b web=%h addr=%h wait=%b dout=%h, expected cs=%b web=f addr=%h wait=%b dout=%h",
                 nm, k, mcs, moe, mweb, maddr, dwait, dout, e_cs, e_addr, e_wait, e_dout);
      end
      if (k == 7) req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_read();
    run_read(32'h0000_0104, 14'h040,
             {32'h1000_0043, 32'h1000_0042, 32'h1000_0041, 32'h1000_0040}, 1'b0, "read");
  endtask

  task automatic test_drop_mid_burst();
    run_read(32'h0000_0104, 14'h040,
             {32'h1000_0043, 32'h1000_0042, 32'h1000_0041, 32'h1000_0040}, 1'b1, "drop");
  endtask

  task automatic test_read_priority();
    strb = 4'b0000; din = 32'h5555_5555;
    run_read(32'h0000_00C8, 14'h030,
             {32'h1000_0033, 32'h1000_0032, 32'h1000_0031, 32'h1000_0030}, 1'b0, "prio");
  endtask

  task automatic test_write_then_read();
    logic e_ex;
    req = 1'b0; strb = 4'b1100; din = 32'hDEAD_BEEF; addr = 32'h0000_0208;
    @(negedge clk);
    strb = 4'hF; din = 32'h0; addr = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      e_ex = (k == 3);
      checks++;
      if (mcs !== e_ex || moe !== 1'b0 || mweb !== (e_ex ? 4'b1100 : 4'hF) ||
          maddr !== (e_ex ? 14'h082 : 14'h0) || mdi !== (e_ex ? 32'hDEAD_BEEF : 32'h0) ||
          dwait !== !e_ex || (!e_ex && dout !== 32'h0)) begin
        failures++;
        $display("FAIL write cyc%0d: cs=%b oe=%b web=%h addr=%h di=%h wait=%b dout=%h, exec expected=%b",
                 k, mcs, moe, mweb, maddr, mdi, dwait, dout, e_ex);
      end
      if (k < 4) @(negedge clk);
    end
    run_read(32'h0000_0208, 14'h080,
             {32'h1000_0083, 32'h1000_BEEF, 32'h1000_0081, 32'h1000_0080}, 1'b0, "readback");
  endtask

  task automatic test_reset_mid_burst();
    logic        e_cs, e_wait;
    logic [31:0] e_dout;
    req = 1'b1; addr = 32'h0000_0300;
    @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      e_cs   = (k >= 3 && k <= 5);
      e_wait = !(k >= 4 && k <= 5);
      e_dout = e_wait ? 32'h0 : 32'h1000_00C0 + 32'(k - 4);
      checks++;
      if (mcs !== e_cs || dwait !== e_wait || dout !== e_dout || mweb !== 4'hF) begin
        failures++;
        $display("FAIL rst_burst cyc%0d: cs=%b wait=%b dout=%h web=%h, expected cs=%b wait=%b dout=%h web=f",
                 k, mcs, dwait, dout, mweb, e_cs, e_wait, e_dout);
      end
      if (k == 5) begin
        rst = 1'b1; req = 1'b0;
      end
      if (k == 6) rst = 1'b0;
      @(negedge clk);
    end
    run_read(32'h0000_0104, 14'h040,
             {32'h1000_0043, 32'h1000_0042, 32'h1000_0041, 32'h1000_0040}, 1'b0, "fresh");
  endtask

  task automatic test_zero_wait_wrap();
    logic        e_cs, e_wait;
    logic [13:0] e_addr;
    logic [31:0] e_dout;
    req0 = 1'b1; addr0 = 32'h0001_0000;
    @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      e_cs   = (k >= 1 && k <= 4);
      e_addr = e_cs ? 14'(k - 1) : 14'h0;
      e_wait = !(k >= 2 && k <= 5);
      e_dout = e_wait ? 32'h0 : 32'h2000_0000 + 32'(k - 2);
      checks++;
      if (mcs0 !== e_cs || maddr0 !== e_addr || dwait0 !== e_wait || dout0 !== e_dout) begin
        failures++;
        $display("FAIL wait0 cyc%0d: cs=%b addr=%h wait=%b dout=%h, expected cs=%b addr=%h wait=%b dout=%h",
                 k, mcs0, maddr0, dwait0, dout0, e_cs, e_addr, e_wait, e_dout);
      end
      if (k == 5) req0 = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    mem_init = 1'b1; rst = 1'b1;
    req = 1'b0; addr = 32'h0; din = 32'h0; strb = 4'hF;
    req0 = 1'b0; addr0 = 32'h0; din0 = 32'h0; strb0 = 4'hF;
    @(negedge clk);
    mem_init = 1'b0;
    test_reset();
    test_idle();
    test_read();
    test_write_then_read();
    test_read_priority();
    test_drop_mid_burst();
    test_reset_mid_burst();
    test_zero_wait_wrap();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
